// File: rtl/word_splitter_pkg.sv
// word_splitter_pkg
//   Shared widths and the lane-index type for the word splitter and its
//   signed max selector.
package word_splitter_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_LANES = 4;

    // Index 0..3 selects lane O1..O4.
    typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/byte_max_sel.sv
// byte_max_sel
//   Combinational signed 4-way maximum over byte lanes.
//   Ports:
//     lanes    in   packed lanes, lanes[0] = O1 ... lanes[3] = O4
//     max_lane out  index of the largest lane (two's complement); ties pick
//                   the lowest index
module byte_max_sel
    import word_splitter_pkg::*;
(
    input  logic [NUM_LANES-1:0][BYTE_W-1:0] lanes,
    output lane_idx_t                        max_lane
);

    logic signed [BYTE_W-1:0] best_val;
    lane_idx_t                best_idx;

    // Linear scan with strict '>' so an equal later lane never displaces an
    // earlier one.
    always_comb begin
        best_val = $signed(lanes[0]);
        best_idx = '0;
        for (int i = 1; i < NUM_LANES; i++) begin
            if ($signed(lanes[i]) > best_val) begin
                best_val = $signed(lanes[i]);
                best_idx = lane_idx_t'(i);
            end
        end
    end

    assign max_lane = best_idx;

endmodule

// File: rtl/word_splitter.sv
// word_splitter
//   Registered 32-bit to 4-byte splitter with per-lane zero/sign flags and a
//   signed max-lane index. One cycle latency, no backpressure.
//   Ports:
//     clk       in   system clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     A         in   input word
//     in_valid  in   capture A (and swap) on this edge
//     swap      in   0 = big-endian split, 1 = little-endian split
//     O1..O4    out  registered byte lanes
//     out_valid out  one-cycle pulse after each capture
//     zero      out  zero[i-1] set when Oi == 0
//     neg       out  neg[i-1] set when Oi bit 7 is set
//     max_lane  out  index of the largest lane under signed compare
module word_splitter
    import word_splitter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] A,
    input  logic              in_valid,
    input  logic              swap,
    output logic [BYTE_W-1:0] O1,
    output logic [BYTE_W-1:0] O2,
    output logic [BYTE_W-1:0] O3,
    output logic [BYTE_W-1:0] O4,
    output logic              out_valid,
    output logic [3:0]        zero,
    output logic [3:0]        neg,
    output lane_idx_t         max_lane
);

    logic [NUM_LANES-1:0][BYTE_W-1:0] lanes_d, lanes_q;
    logic [NUM_LANES-1:0]             zero_d, zero_q;
    logic [NUM_LANES-1:0]             neg_d, neg_q;
    lane_idx_t                        max_d, max_q;
    logic                             valid_q;

    // lanes_d[0] feeds O1; swap reverses the byte order.
    always_comb begin
        if (swap) begin
            lanes_d[0] = A[7:0];
            lanes_d[1] = A[15:8];
            lanes_d[2] = A[23:16];
            lanes_d[3] = A[31:24];
        end else begin
            lanes_d[0] = A[31:24];
            lanes_d[1] = A[23:16];
            lanes_d[2] = A[15:8];
            lanes_d[3] = A[7:0];
        end
    end

    always_comb begin
        zero_d = '0;
        neg_d  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            zero_d[i] = (lanes_d[i] == '0);
            neg_d[i]  = lanes_d[i][BYTE_W-1];
        end
    end

    byte_max_sel u_max_sel (
        .lanes    (lanes_d),
        .max_lane (max_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
            zero_q  <= '1;
            neg_q   <= '0;
            max_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                lanes_q <= lanes_d;
                zero_q  <= zero_d;
                neg_q   <= neg_d;
                max_q   <= max_d;
            end
        end
    end

    assign O1        = lanes_q[0];
    assign O2        = lanes_q[1];
    assign O3        = lanes_q[2];
    assign O4        = lanes_q[3];
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign max_lane  = max_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_word_splitter.sv
module tb_word_splitter;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic        in_valid;
    logic        swap;
    logic [7:0]  O1, O2, O3, O4;
    logic        out_valid;
    logic [3:0]  zero;
    logic [3:0]  neg;
    logic [1:0]  max_lane;

    int checks = 0;
    int errors = 0;

    // Reference state: what the outputs should currently show.
    logic [7:0] exp_lane [4];
    logic       exp_valid;

    word_splitter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .in_valid  (in_valid),
        .swap      (swap),
        .O1        (O1),
        .O2        (O2),
        .O3        (O3),
        .O4        (O4),
        .out_valid (out_valid),
        .zero      (zero),
        .neg       (neg),
        .max_lane  (max_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_lane[i] = 8'h00;
        exp_valid = 1'b0;
    endtask

    // Lane i is the byte at shift (24 - 8i) for big-endian, 8i for swapped.
    task automatic model_capture(input logic [31:0] a, input logic s);
        for (int i = 0; i < 4; i++) begin
            int sh;
            sh = s ? 8 * i : 24 - 8 * i;
            exp_lane[i] = 8'((a >> sh) & 32'hFF);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] ez, en;
        int best, best_v, v;
        best = 0;
        best_v = -1000;
        for (int i = 0; i < 4; i++) begin
            v = (exp_lane[i] >= 8'd128) ? int'(exp_lane[i]) - 256 : int'(exp_lane[i]);
            ez[i] = (exp_lane[i] == 8'd0);
            en[i] = (v < 0);
            if (v > best_v) begin
                best_v = v;
                best = i;
            end
        end
        chk({tag, ".O1"}, {24'd0, O1}, {24'd0, exp_lane[0]});
        chk({tag, ".O2"}, {24'd0, O2}, {24'd0, exp_lane[1]});
        chk({tag, ".O3"}, {24'd0, O3}, {24'd0, exp_lane[2]});
        chk({tag, ".O4"}, {24'd0, O4}, {24'd0, exp_lane[3]});
        chk({tag, ".zero"}, {28'd0, zero}, {28'd0, ez});
        chk({tag, ".neg"}, {28'd0, neg}, {28'd0, en});
        chk({tag, ".max_lane"}, {30'd0, max_lane}, 32'(best));
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    endtask

    // Drive one cycle of input, let the edge pass, update the model, check.
    task automatic step(input string tag, input logic [31:0] a, input logic v, input logic s);
        @(negedge clk);
        A = a;
        in_valid = v;
        swap = s;
        @(posedge clk);
        #1;
        if (v) model_capture(a, s);
        exp_valid = v;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        A = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        swap = 1'b0;
        model_reset();

        // Reset holds outputs despite active input.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");

        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("release");

        // Directed vectors.
        step("be_split", 32'h2103_0000, 1'b1, 1'b0);
        chk("be_O1_dec", {24'd0, O1}, 32'd33);
        chk("be_zero_lit", {28'd0, zero}, 32'b1100);
        step("be_drop", 32'h0000_0000, 1'b0, 1'b0);
        step("swap", 32'h1122_3344, 1'b1, 1'b1);
        chk("swap_O1_lit", {24'd0, O1}, 32'h44);
        step("signed", 32'hFF01_807F, 1'b1, 1'b0);
        chk("signed_neg_lit", {28'd0, neg}, 32'b0101);
        chk("signed_max_lit", {30'd0, max_lane}, 32'd3);
        step("tie", 32'h0505_0505, 1'b1, 1'b0);
        chk("tie_max_lit", {30'd0, max_lane}, 32'd0);
        step("b2b_a", 32'hAABB_CCDD, 1'b1, 1'b0);
        step("b2b_b", 32'h0102_0304, 1'b1, 1'b0);
        step("hold1", 32'hDEAD_BEEF, 1'b0, 1'b1);
        step("hold2", 32'h1234_5678, 1'b0, 1'b0);
        chk("hold_O4_lit", {24'd0, O4}, 32'h04);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            step("rand", $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        // Async reset between edges, with non-zero outputs.
        step("pre_areset", 32'h8090_A0B0, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        A = 32'h7777_7777;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("async_reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_areset");
        step("after_reset", 32'h0080_7F01, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
